// File: rtl/led_run_core_if.sv
// LED drive bus between the marquee core and the pin/consumer side.
// Latency: none, plain wires.
// Backpressure: none; the LED bus is a free-running level output.
interface led_run_core_if;
    logic [7:0] led;

    // The core drives the LED bank.
    modport master (output led);

    // Pins, monitors or a testbench observe it.
    modport slave (input led);
endinterface

// File: rtl/led_run_core.sv
// Running-light driver for an 8-LED bank: one lit LED that steps every TICK_CNT cycles.
// Latency: the first step lands TICK_CNT edges after reset release, then one step every TICK_CNT edges.
// Backpressure: none; the core free-runs whenever it is out of reset.
module led_run_core #(
    parameter int unsigned TICK_CNT       = 25_000_000,
    parameter bit          BOUNCE         = 1'b0,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,    // active-high despite the name
    led_run_core_if.master bus
);

    // Last prescaler value; the tick fires here and the counter wraps to zero.
    localparam logic [31:0] CNT_LAST = TICK_CNT - 32'd1;
    localparam logic [7:0]  PAT_INIT = 8'h01;
    localparam logic [7:0]  PAT_MSB  = 8'h80;
    localparam logic [7:0]  PAT_LSB  = 8'h01;

    // Direction only matters in ping-pong mode; rotation always moves left.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [31:0] cnt;
    logic        tick;
    logic [7:0]  pat;
    logic [7:0]  pat_nxt;
    dir_t        dir;
    dir_t        dir_nxt;
    logic        pat_onehot;

    // Prescaler: counts 0..TICK_CNT-1 and wraps, producing a one-cycle tick at the top.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign tick = (cnt == CNT_LAST);

    // A single set bit means the pattern is sane; anything else is treated as corruption.
    assign pat_onehot = (pat != 8'h00) && ((pat & (pat - 8'h01)) == 8'h00);

    // Pattern and direction registers; only ever move on a tick.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pat <= PAT_INIT;
            dir <= DIR_LEFT;
        end else begin
            pat <= pat_nxt;
            dir <= dir_nxt;
        end
    end

    // Next-state logic: hold between ticks, recover from corruption, otherwise step the light.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (tick) begin
            if (!pat_onehot) begin
                // Recover to a known position rather than shifting garbage around.
                pat_nxt = PAT_INIT;
                dir_nxt = DIR_LEFT;
            end else if (!BOUNCE) begin
                // Circular left rotation; MSB wraps straight back to LSB.
                pat_nxt = {pat[6:0], pat[7]};
                dir_nxt = DIR_LEFT;
            end else begin
                // Ping-pong: turn around at each end so each end LED is lit for one step only.
                case (dir)
                    DIR_LEFT: begin
                        if (pat == PAT_MSB) begin
                            pat_nxt = {1'b0, pat[7:1]};
                            dir_nxt = DIR_RIGHT;
                        end else begin
                            pat_nxt = {pat[6:0], 1'b0};
                        end
                    end
                    DIR_RIGHT: begin
                        if (pat == PAT_LSB) begin
                            pat_nxt = {pat[6:0], 1'b0};
                            dir_nxt = DIR_LEFT;
                        end else begin
                            pat_nxt = {1'b0, pat[7:1]};
                        end
                    end
                    default: begin
                        pat_nxt = PAT_INIT;
                        dir_nxt = DIR_LEFT;
                    end
                endcase
            end
        end
    end

    // LED drive straight from the pattern register, optionally inverted for sinking drivers.
    generate
        if (LED_ACTIVE_LOW) begin : g_active_low
            assign bus.led = ~pat;
        end else begin : g_active_high
            assign bus.led = pat;
        end
    endgenerate

endmodule

// File: tb/tb_led_run_core.sv
// Directed bench for led_run_core: rotation, ping-pong, active-low and default-rate instances.
// Latency: checks sample on the falling edge after each counted rising edge.
// Backpressure: not applicable; the DUT has no inputs besides clock and reset.
module tb_led_run_core;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    logic rst_d;

    int checks;
    int errors;

    led_run_core_if if_a ();
    led_run_core_if if_b ();
    led_run_core_if if_c ();
    led_run_core_if if_d ();

    led_run_core #(.TICK_CNT(4), .BOUNCE(1'b0), .LED_ACTIVE_LOW(1'b0)) dut_a (
        .clk (clk),
        .rstn(rst_a),
        .bus (if_a)
    );

    led_run_core #(.TICK_CNT(3), .BOUNCE(1'b1), .LED_ACTIVE_LOW(1'b0)) dut_b (
        .clk (clk),
        .rstn(rst_b),
        .bus (if_b)
    );

    led_run_core #(.TICK_CNT(2), .BOUNCE(1'b0), .LED_ACTIVE_LOW(1'b1)) dut_c (
        .clk (clk),
        .rstn(rst_c),
        .bus (if_c)
    );

    led_run_core dut_d (
        .clk (clk),
        .rstn(rst_d),
        .bus (if_d)
    );

    // 50 MHz clock: rising edges at 10, 30, 50 ns ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (if_a.led !== 8'h01) begin
            errors++;
            $display("FAIL reset_async led=%h expected=%h", if_a.led, 8'h01);
        end
        #200;
        rst_a = 1'b0;
        step(3);
        checks++;
        if (if_a.led !== 8'h01) begin
            errors++;
            $display("FAIL reset_hold3 led=%h expected=%h", if_a.led, 8'h01);
        end
        step(1);
        checks++;
        if (if_a.led !== 8'h02) begin
            errors++;
            $display("FAIL reset_first_step led=%h expected=%h", if_a.led, 8'h02);
        end
    endtask

    task automatic test_rotation;
        logic [7:0] one;
        logic [7:0] exp;
        one = 8'h01;
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        rst_a = 1'b0;
        for (int e = 0; e <= 34; e++) begin
            if (e > 0) step(1);
            exp = one << ((e / 4) % 8);
            checks++;
            if (if_a.led !== exp) begin
                errors++;
                $display("FAIL rotation edge=%0d led=%h expected=%h", e, if_a.led, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        rst_a = 1'b0;
        step(17);
        checks++;
        if (if_a.led !== 8'h10) begin
            errors++;
            $display("FAIL midrun_before led=%h expected=%h", if_a.led, 8'h10);
        end
        #2;
        rst_a = 1'b1;
        #1;
        checks++;
        if (if_a.led !== 8'h01) begin
            errors++;
            $display("FAIL midrun_async led=%h expected=%h", if_a.led, 8'h01);
        end
        step(1);
        checks++;
        if (if_a.led !== 8'h01) begin
            errors++;
            $display("FAIL midrun_held led=%h expected=%h", if_a.led, 8'h01);
        end
        rst_a = 1'b0;
        step(3);
        checks++;
        if (if_a.led !== 8'h01) begin
            errors++;
            $display("FAIL midrun_hold3 led=%h expected=%h", if_a.led, 8'h01);
        end
        step(1);
        checks++;
        if (if_a.led !== 8'h02) begin
            errors++;
            $display("FAIL midrun_step led=%h expected=%h", if_a.led, 8'h02);
        end
    endtask

    task automatic test_ping_pong;
        logic [7:0] seq [14];
        int         n_msb;
        int         n_lsb;
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        n_msb = 0;
        n_lsb = 0;
        @(negedge clk);
        rst_b = 1'b0;
        // 85 samples = two full passes (84 edges) plus the return to 0x01.
        for (int e = 0; e <= 84; e++) begin
            if (e > 0) step(1);
            checks++;
            if (if_b.led !== seq[(e / 3) % 14]) begin
                errors++;
                $display("FAIL pingpong edge=%0d led=%h expected=%h", e, if_b.led, seq[(e / 3) % 14]);
            end
            if (e < 42 && if_b.led === 8'h80) n_msb++;
            if (e < 42 && if_b.led === 8'h01) n_lsb++;
        end
        // One pass is 14 steps of 3 cycles: each end lit for exactly one step.
        checks++;
        if (n_msb !== 3) begin
            errors++;
            $display("FAIL pingpong_msb_cycles count=%0d expected=%0d", n_msb, 3);
        end
        checks++;
        if (n_lsb !== 3) begin
            errors++;
            $display("FAIL pingpong_lsb_cycles count=%0d expected=%0d", n_lsb, 3);
        end
    endtask

    task automatic test_active_low;
        logic [7:0] one;
        logic [7:0] exp;
        one = 8'h01;
        checks++;
        if (if_c.led !== 8'hFE) begin
            errors++;
            $display("FAIL activelow_reset led=%h expected=%h", if_c.led, 8'hFE);
        end
        @(negedge clk);
        rst_c = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) step(1);
            exp = ~(one << ((e / 2) % 8));
            checks++;
            if (if_c.led !== exp) begin
                errors++;
                $display("FAIL activelow edge=%0d led=%h expected=%h", e, if_c.led, exp);
            end
            checks++;
            if ($countones(~if_c.led) !== 1) begin
                errors++;
                $display("FAIL activelow_onecold edge=%0d low_bits=%0d expected=%0d", e, $countones(~if_c.led), 1);
            end
        end
    endtask

    task automatic test_long_run;
        @(negedge clk);
        rst_d = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1000);
            checks++;
            if (if_d.led !== 8'h01) begin
                errors++;
                $display("FAIL longrun_led edge=%0d led=%h expected=%h", i * 1000, if_d.led, 8'h01);
            end
            checks++;
            if (dut_d.cnt !== 32'(i * 1000)) begin
                errors++;
                $display("FAIL longrun_cnt edge=%0d cnt=%0d expected=%0d", i * 1000, dut_d.cnt, i * 1000);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        rst_c  = 1'b1;
        rst_d  = 1'b1;
        test_reset();
        test_rotation();
        test_reset_mid_run();
        test_ping_pong();
        test_active_low();
        test_long_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
